// File: rtl/board_uart_streamer.sv
// Streams a 9x9 board as ASCII over a byte-wide UART transmitter (uart_tx8).
// Each row is nine cell characters followed by CR LF, so a frame is 99 bytes.
// Optional feature: define STREAM_HEADER_EN to prefix each frame with "#\r\n".
// Every byte goes through the same handshake: start pulse, wait for uart_busy to
// rise, then wait for it to fall.
module board_uart_streamer (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       send,
  output logic [6:0] cell_addr,
  input  logic [3:0] cell_val,
  input  logic       uart_busy,
  output logic [7:0] data,
  output logic       start,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {StIdle, StEmit, StWaitAck, StWaitDone} state_e;

  state_e     state_q, state_d;
  logic [3:0] row_q;      // 0..8
  logic [3:0] col_q;      // 0..8 cells, 9 = CR, 10 = LF
  logic [6:0] addr_q;
  logic [7:0] data_q;
  logic       busy_q;
  logic       done_q;
  logic [7:0] char_now;
  logic       last_byte;
  logic       accept;
  logic       emit_fire;
  logic       byte_done;
  logic       advance;
  logic       finish;

`ifdef STREAM_HEADER_EN
  logic       hdr_act_q;
  logic [1:0] hdr_idx_q;
`endif

  // Handshake qualifiers shared by the FSM and the datapath.
  always_comb begin
    accept    = (state_q == StIdle) && send;
    // Extra guard: never start while the transmitter still reports busy.
    emit_fire = (state_q == StEmit) && !uart_busy;
    byte_done = (state_q == StWaitDone) && !uart_busy;
`ifdef STREAM_HEADER_EN
    last_byte = !hdr_act_q && (row_q == 4'd8) && (col_q == 4'd10);
`else
    last_byte = (row_q == 4'd8) && (col_q == 4'd10);
`endif
    advance   = byte_done && !last_byte;
    finish    = byte_done && last_byte;
  end

  // Character for the current frame position.
  always_comb begin
    char_now = 8'h00;
    if (col_q == 4'd9) begin
      char_now = 8'h0D;
    end else if (col_q == 4'd10) begin
      char_now = 8'h0A;
    end else if (cell_val == 4'd0) begin
      char_now = 8'h2E;
    end else if (cell_val <= 4'd9) begin
      char_now = 8'h30 + {4'h0, cell_val};
    end else begin
      char_now = 8'h3F;
    end
`ifdef STREAM_HEADER_EN
    if (hdr_act_q) begin
      unique case (hdr_idx_q)
        2'd0:    char_now = 8'h23;
        2'd1:    char_now = 8'h0D;
        default: char_now = 8'h0A;
      endcase
    end
`endif
  end

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (send)       state_d = StEmit;
      StEmit:     if (!uart_busy) state_d = StWaitAck;
      StWaitAck:  if (uart_busy)  state_d = StWaitDone;
      StWaitDone: begin
        if (!uart_busy) state_d = last_byte ? StIdle : StEmit;
      end
      default:    state_d = StIdle;
    endcase
  end

  // Outputs; data follows the live character during the start cycle so the
  // transmitter latches the right byte, then holds until the next emit.
  always_comb begin
    start     = emit_fire;
    data      = emit_fire ? char_now : data_q;
    busy      = busy_q;
    done      = done_q;
    cell_addr = addr_q;
  end

  // Position counters, read address, held data byte and status flags.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      row_q     <= 4'd0;
      col_q     <= 4'd0;
      addr_q    <= 7'd0;
      data_q    <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef STREAM_HEADER_EN
      hdr_act_q <= 1'b0;
      hdr_idx_q <= 2'd0;
`endif
    end else begin
      done_q <= finish;
      if (finish) begin
        busy_q <= 1'b0;
      end
      if (emit_fire) begin
        data_q <= char_now;
      end
      if (accept) begin
        row_q     <= 4'd0;
        col_q     <= 4'd0;
        addr_q    <= 7'd0;
        busy_q    <= 1'b1;
`ifdef STREAM_HEADER_EN
        hdr_act_q <= 1'b1;
        hdr_idx_q <= 2'd0;
`endif
      end
`ifdef STREAM_HEADER_EN
      if (advance && hdr_act_q) begin
        if (hdr_idx_q == 2'd2) begin
          hdr_act_q <= 1'b0;
        end else begin
          hdr_idx_q <= hdr_idx_q + 2'd1;
        end
      end else if (advance) begin
`else
      if (advance) begin
`endif
        if (col_q == 4'd10) begin
          col_q <= 4'd0;
          row_q <= row_q + 4'd1;
        end else begin
          col_q <= col_q + 4'd1;
        end
        // The address only moves when the next position is a cell; it holds
        // across CR/LF, and row*9+8 -> (row+1)*9 is again a plain increment.
        if ((col_q == 4'd10) || (col_q < 4'd8)) begin
          addr_q <= addr_q + 7'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_board_uart_streamer.sv
// Directed bench for board_uart_streamer with a uart_tx8 model that holds busy
// for a fixed number of cycles after each start. Expected frames are built from
// the board at send time and compared against the captured byte stream.
module tb_board_uart_streamer;

  localparam int NBusy = 3;
`ifdef STREAM_HEADER_EN
  localparam int FrameLen = 102;
`else
  localparam int FrameLen = 99;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       send;
  logic [6:0] cell_addr;
  logic [3:0] cell_val;
  logic       uart_busy = 1'b0;
  logic [7:0] data;
  logic       start;
  logic       busy;
  logic       done;

  logic [3:0] board [0:80];
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  int         ucnt = 0;
  int         done_cnt = 0;
  int         bad_start = 0;
  int         n_cmp = 0;
  int         n_mis = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  assign cell_val = (cell_addr < 7'd81) ? board[cell_addr] : 4'hF;

  board_uart_streamer dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .send      (send),
    .cell_addr (cell_addr),
    .cell_val  (cell_val),
    .uart_busy (uart_busy),
    .data      (data),
    .start     (start),
    .busy      (busy),
    .done      (done)
  );

  // uart_tx8 model: latch data on start, then report busy for NBusy cycles.
  always @(posedge CLOCK_50) begin
    if (start) begin
      if (uart_busy) bad_start <= bad_start + 1;
      got_q.push_back(data);
      uart_busy <= 1'b1;
      ucnt      <= NBusy;
    end else if (ucnt > 1) begin
      ucnt <= ucnt - 1;
    end else if (ucnt == 1) begin
      ucnt      <= 0;
      uart_busy <= 1'b0;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] cell_char(input logic [3:0] v);
    if (v == 4'd0) return 8'h2E;
    if (v <= 4'd9) return 8'h30 + {4'h0, v};
    return 8'h3F;
  endfunction

  task automatic push_frame();
    exp_q.delete();
`ifdef STREAM_HEADER_EN
    exp_q.push_back(8'h23);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
    for (int r = 0; r < 9; r++) begin
      for (int c = 0; c < 9; c++) exp_q.push_back(cell_char(board[r * 9 + c]));
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  task automatic fill_board(input logic [3:0] v);
    for (int i = 0; i < 81; i++) board[i] = v;
  endtask

  // Pulse send for one cycle and check the first start follows one cycle later.
  task automatic do_send(input string tag);
    @(negedge CLOCK_50);
    send = 1'b1;
    push_frame();
    @(negedge CLOCK_50);
    send = 1'b0;
    check({tag, " first start"}, start, 1'b1);
    check({tag, " busy set"}, busy, 1'b1);
    check({tag, " addr0"}, cell_addr, 7'd0);
  endtask

  task automatic wait_bytes(input string tag, input int n);
    int k = 0;
    while (got_q.size() < n && k < 5000) begin
      @(negedge CLOCK_50);
      k++;
    end
    check({tag, " reached byte"}, got_q.size() >= n, 1'b1);
  endtask

  // Wait for the final-byte completion cycle, optionally pulse send there,
  // then check done, the byte count and the frame contents.
  task automatic finish_frame(input string tag, input int base, input int d0, input bit race);
    int k = 0;
    while (!(got_q.size() >= base + FrameLen && uart_busy === 1'b0) && k < 5000) begin
      @(negedge CLOCK_50);
      k++;
    end
    check({tag, " frame end seen"}, k < 5000, 1'b1);
    check({tag, " no early done"}, done_cnt - d0, 0);
    if (race) send = 1'b1;
    @(negedge CLOCK_50);
    send = 1'b0;
    check({tag, " done pulse"}, done, 1'b1);
    check({tag, " busy clear"}, busy, 1'b0);
    repeat (30) @(negedge CLOCK_50);
    check({tag, " done count"}, done_cnt - d0, 1);
    check({tag, " byte count"}, got_q.size() - base, FrameLen);
    check({tag, " start while busy"}, bad_start, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [7:0] e;
      logic [31:0] o;
      e = exp_q.pop_front();
      o = (base + i < got_q.size()) ? {24'h0, got_q[base + i]} : 32'hDEAD;
      check($sformatf("%s byte%0d", tag, i), o, {24'h0, e});
    end
  endtask

  initial begin
    int base;
    int d0;
    reset = 1'b1;
    send  = 1'b0;
    fill_board(4'd0);
    repeat (3) @(negedge CLOCK_50);
    check("rst start", start, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst data", data, 8'h00);
    check("rst addr", cell_addr, 7'd0);
    reset = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    check("idle start", start, 1'b0);

    // All-zero board; send again in the completion cycle must be ignored.
    base = got_q.size();
    d0   = done_cnt;
    do_send("zero");
    finish_frame("zero", base, d0, 1'b1);

    // Mixed board; cell 0 changes after it was sent and must not matter.
    fill_board(4'd3);
    board[0]  = 4'd5;
    board[80] = 4'd9;
    base = got_q.size();
    d0   = done_cnt;
    do_send("mix");
    wait_bytes("mix", base + 6);
    board[0] = 4'd1;
    finish_frame("mix", base, d0, 1'b0);

    // Out-of-range cell value, plus a send pulse mid-frame.
    fill_board(4'd0);
    board[40] = 4'd12;
    base = got_q.size();
    d0   = done_cnt;
    do_send("resend");
    wait_bytes("resend", base + 20);
    @(negedge CLOCK_50);
    send = 1'b1;
    @(negedge CLOCK_50);
    send = 1'b0;
    finish_frame("resend", base, d0, 1'b0);

    // Reset mid-frame, then a fresh frame from the top.
    fill_board(4'd7);
    board[0] = 4'd0;
    base = got_q.size();
    d0   = done_cnt;
    do_send("abort");
    wait_bytes("abort", base + 50);
    @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    check("abort start", start, 1'b0);
    check("abort busy", busy, 1'b0);
    check("abort addr", cell_addr, 7'd0);
    repeat (20) @(negedge CLOCK_50);
    check("abort no done", done_cnt - d0, 0);
    check("abort quiet", busy, 1'b0);
    base = got_q.size();
    d0   = done_cnt;
    do_send("restart");
    finish_frame("restart", base, d0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
